prog_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-bit up-counter.
- Configurable width, modulus, prescaler and direction, plus free-run and one-shot modes, synchronous load, and start/stop control.
- Emits a terminal-count pulse and status flags.
- Used as the general timing/event counter in the fabric test designs, driven directly from the bench's clk/reset.

---
 rtl/prog_counter.sv | 175 +++++++++++++++++
 tb/tb_prog_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Programmable up/down event counter with prescaler, free-run/one-shot modes,
// synchronous load and start/stop control; emits a registered terminal-count pulse.

// Invariant checks on the counter outputs.
module prog_counter_chk #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input logic             clk,
  input logic             reset,
  input logic [WIDTH-1:0] out,
  input logic             tc,
  input logic             busy,
  input logic             done
);

  a_out_in_range: assert property (@(posedge clk) disable iff (!reset)
    int'(out) < MODULO);

  a_state_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(busy && done));

  a_tc_only_active: assert property (@(posedge clk) disable iff (!reset)
    tc |-> (busy || done));

endmodule

module prog_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    PSC_LAST = PW'(PRESCALE - 1);

  state_t           state_r;
  logic [WIDTH-1:0] out_r;
  logic [PW-1:0]    psc_r;
  logic             tc_r;

  logic             tick_s;
  logic             wrap_s;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] load_clamp_s;

  // Tick qualification, wrap detection and the candidate next count.
  always_comb begin
    tick_s       = 1'b0;
    wrap_s       = 1'b0;
    step_s       = out_r;
    load_clamp_s = load_val;
    if ((state_r == RUN) && en && (psc_r == PSC_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (dir) begin
      wrap_s = (out_r == MAX_VAL);
      step_s = wrap_s ? {WIDTH{1'b0}} : (out_r + WIDTH'(1'b1));
    end else begin
      wrap_s = (out_r == {WIDTH{1'b0}});
      step_s = wrap_s ? MAX_VAL : (out_r - WIDTH'(1'b1));
    end
    // Out-of-range load values saturate so out never leaves 0..MODULO-1.
    if (int'(load_val) > (MODULO - 1)) begin
      load_clamp_s = MAX_VAL;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Control FSM, count register, prescaler and terminal-count pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      out_r   <= {WIDTH{1'b0}};
      psc_r   <= {PW{1'b0}};
      tc_r    <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (load) begin
        out_r <= load_clamp_s;
        psc_r <= {PW{1'b0}};
        case (state_r)
          IDLE:    state_r <= start ? RUN : IDLE;
          RUN:     state_r <= stop ? IDLE : RUN;
          DONE:    state_r <= start ? RUN : IDLE;
          default: state_r <= IDLE;
        endcase
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              state_r <= RUN;
              psc_r   <= {PW{1'b0}};
            end else begin
              state_r <= IDLE;
            end
          end
          RUN: begin
            if (stop) begin
              state_r <= IDLE;
              psc_r   <= {PW{1'b0}};
            end else if (tick_s) begin
              psc_r <= {PW{1'b0}};
              tc_r  <= wrap_s;
              // One-shot holds the terminal value instead of wrapping.
              if (wrap_s && mode) begin
                state_r <= DONE;
              end else begin
                out_r <= step_s;
              end
            end else if (en) begin
              psc_r <= psc_r + PW'(1'b1);
            end else begin
              psc_r <= psc_r;
            end
          end
          DONE: begin
            if (start) begin
              state_r <= RUN;
              psc_r   <= {PW{1'b0}};
            end else begin
              state_r <= DONE;
            end
          end
          default: begin
            state_r <= IDLE;
            psc_r   <= {PW{1'b0}};
          end
        endcase
      end
    end
  end

  assign out  = out_r;
  assign tc   = tc_r;
  assign busy = (state_r == RUN);
  assign done = (state_r == DONE);

  prog_counter_chk #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .out   (out_r),
    .tc    (tc_r),
    .busy  (busy),
    .done  (done)
  );

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: four instances cover modulus, prescaler,
// direction, one-shot and async-reset behaviour with hand-computed expectations.
module tb_prog_counter;

  logic       clk;
  logic       reset;
  logic       en_a    [4];
  logic       start_a [4];
  logic       stop_a  [4];
  logic       load_a  [4];
  logic [3:0] lv_a    [4];
  logic       dir_a   [4];
  logic       mode_a  [4];
  logic [3:0] out_a   [4];
  logic       tc_a    [4];
  logic       busy_a  [4];
  logic       done_a  [4];

  typedef struct {
    int         d;
    logic [3:0] out;
    logic       tc;
    logic       busy;
    logic       done;
    string      nm;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prog_counter #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) u0 (
    .clk(clk), .reset(reset), .en(en_a[0]), .start(start_a[0]), .stop(stop_a[0]),
    .load(load_a[0]), .load_val(lv_a[0]), .dir(dir_a[0]), .mode(mode_a[0]),
    .out(out_a[0]), .tc(tc_a[0]), .busy(busy_a[0]), .done(done_a[0]));

  prog_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .en(en_a[1]), .start(start_a[1]), .stop(stop_a[1]),
    .load(load_a[1]), .load_val(lv_a[1]), .dir(dir_a[1]), .mode(mode_a[1]),
    .out(out_a[1]), .tc(tc_a[1]), .busy(busy_a[1]), .done(done_a[1]));

  prog_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) u2 (
    .clk(clk), .reset(reset), .en(en_a[2]), .start(start_a[2]), .stop(stop_a[2]),
    .load(load_a[2]), .load_val(lv_a[2]), .dir(dir_a[2]), .mode(mode_a[2]),
    .out(out_a[2]), .tc(tc_a[2]), .busy(busy_a[2]), .done(done_a[2]));

  prog_counter #(.WIDTH(4), .MODULO(6), .PRESCALE(1)) u3 (
    .clk(clk), .reset(reset), .en(en_a[3]), .start(start_a[3]), .stop(stop_a[3]),
    .load(load_a[3]), .load_val(lv_a[3]), .dir(dir_a[3]), .mode(mode_a[3]),
    .out(out_a[3]), .tc(tc_a[3]), .busy(busy_a[3]), .done(done_a[3]));

  task automatic check(input string nm, input int d, input logic [3:0] eo,
                       input logic etc, input logic eb, input logic ed);
    n_cmp++;
    if (out_a[d] !== eo || tc_a[d] !== etc || busy_a[d] !== eb || done_a[d] !== ed) begin
      n_bad++;
      $display("FAIL %s dut%0d: got out=%0d tc=%b busy=%b done=%b, want out=%0d tc=%b busy=%b done=%b",
               nm, d, out_a[d], tc_a[d], busy_a[d], done_a[d], eo, etc, eb, ed);
    end
  endtask

  // Drive one cycle of inputs on dut d and queue the state expected after the next edge.
  task automatic drive(input int d, input logic e, input logic st, input logic sp,
                       input logic ld, input logic [3:0] lv, input logic dr, input logic md,
                       input logic [3:0] eo, input logic etc, input logic eb, input logic ed,
                       input string nm);
    exp_t x;
    @(negedge clk);
    en_a[d]    = e;
    start_a[d] = st;
    stop_a[d]  = sp;
    load_a[d]  = ld;
    lv_a[d]    = lv;
    dir_a[d]   = dr;
    mode_a[d]  = md;
    x.d    = d;
    x.out  = eo;
    x.tc   = etc;
    x.busy = eb;
    x.done = ed;
    x.nm   = nm;
    sb.push_back(x);
  endtask

  // Monitor: one expectation per active edge, sampled just after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check(x.nm, x.d, x.out, x.tc, x.busy, x.done);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en_a[i] = 1'b0; start_a[i] = 1'b0; stop_a[i] = 1'b0; load_a[i] = 1'b0;
      lv_a[i] = 4'd0; dir_a[i] = 1'b0; mode_a[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < 4; i++) check("reset", i, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Free-run up, modulus 16
    drive(0, 1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "t1_start");
    for (int k = 1; k <= 17; k++)
      drive(0, 1, 0, 0, 0, 4'd0, 1, 0, 4'(k % 16), (k == 16), 1, 0, "t1_up");
    drive(0, 1, 0, 1, 0, 4'd0, 1, 0, 4'd1, 0, 0, 0, "t1_stop");

    // Free-run down, modulus 10, load with start, clamp
    drive(1, 1, 1, 0, 1, 4'd3,  0, 0, 4'd3, 0, 1, 0, "t2_load_start");
    drive(1, 1, 0, 0, 0, 4'd0,  0, 0, 4'd2, 0, 1, 0, "t2_down");
    drive(1, 1, 0, 0, 0, 4'd0,  0, 0, 4'd1, 0, 1, 0, "t2_down");
    drive(1, 1, 0, 0, 0, 4'd0,  0, 0, 4'd0, 0, 1, 0, "t2_down");
    drive(1, 1, 0, 0, 0, 4'd0,  0, 0, 4'd9, 1, 1, 0, "t2_wrap");
    drive(1, 1, 0, 0, 0, 4'd0,  0, 0, 4'd8, 0, 1, 0, "t2_down");
    drive(1, 1, 0, 0, 0, 4'd0,  0, 0, 4'd7, 0, 1, 0, "t2_down");
    drive(1, 1, 0, 0, 1, 4'd12, 0, 0, 4'd9, 0, 1, 0, "t2_clamp");
    drive(1, 1, 0, 1, 0, 4'd0,  0, 0, 4'd9, 0, 0, 0, "t2_stop");

    // Stop beats start; resume continues from held value
    drive(1, 1, 1, 0, 1, 4'd7, 1, 0, 4'd7, 0, 1, 0, "t5_load7");
    drive(1, 1, 1, 1, 0, 4'd0, 1, 0, 4'd7, 0, 0, 0, "t5_stop_start");
    drive(1, 1, 0, 0, 0, 4'd0, 1, 0, 4'd7, 0, 0, 0, "t5_idle");
    drive(1, 1, 1, 0, 0, 4'd0, 1, 0, 4'd7, 0, 1, 0, "t5_restart");
    drive(1, 1, 0, 0, 0, 4'd0, 1, 0, 4'd8, 0, 1, 0, "t5_resume");

    // Asynchronous reset mid-count at out=5
    drive(1, 1, 0, 0, 1, 4'd3, 1, 0, 4'd3, 0, 1, 0, "t6_load3");
    drive(1, 1, 0, 0, 0, 4'd0, 1, 0, 4'd4, 0, 1, 0, "t6_up");
    drive(1, 1, 0, 0, 0, 4'd0, 1, 0, 4'd5, 0, 1, 0, "t6_up");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_reset", 1, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 0, "t6_idle");
    drive(1, 1, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 0, "t6_idle");
    drive(1, 1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "t6_start");
    drive(1, 1, 0, 0, 0, 4'd0, 1, 0, 4'd1, 0, 1, 0, "t6_up");

    // Prescale 3 with en frozen for 4 cycles (prescaler sits at 2)
    drive(2, 1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "t3_start");
    drive(2, 1, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "t3_pre");
    drive(2, 1, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "t3_pre");
    for (int k = 0; k < 4; k++)
      drive(2, 0, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "t3_frozen");
    for (int k = 0; k < 7; k++)
      drive(2, 1, 0, 0, 0, 4'd0, 1, 0, 4'(1 + k / 3), 0, 1, 0, "t3_prescale");

    // One-shot up, modulus 6
    drive(3, 1, 1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0, "t4_start");
    for (int k = 1; k <= 5; k++)
      drive(3, 1, 0, 0, 0, 4'd0, 1, 1, 4'(k), 0, 1, 0, "t4_up");
    drive(3, 1, 0, 0, 0, 4'd0, 1, 1, 4'd5, 1, 0, 1, "t4_terminal");
    for (int k = 0; k < 10; k++)
      drive(3, 1, 0, 0, 0, 4'd0, 1, 1, 4'd5, 0, 0, 1, "t4_hold");
    drive(3, 1, 1, 0, 0, 4'd0, 1, 1, 4'd5, 0, 1, 0, "t4_restart");
    drive(3, 1, 0, 0, 0, 4'd0, 1, 1, 4'd5, 1, 0, 1, "t4_refire");
    drive(3, 1, 0, 0, 1, 4'd0, 1, 1, 4'd0, 0, 0, 0, "t4_load0");
    drive(3, 1, 1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0, "t4_start2");
    for (int k = 1; k <= 5; k++)
      drive(3, 1, 0, 0, 0, 4'd0, 1, 1, 4'(k), 0, 1, 0, "t4_up2");
    drive(3, 1, 0, 0, 0, 4'd0, 1, 1, 4'd5, 1, 0, 1, "t4_terminal2");

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
